// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the execute stage: iterative MULT/MULTU/DIV/DIVU plus
// single-cycle MTHI/MTLO, with a busy flag for issue stalls.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;

    logic               op_arith, op_mthi, op_mtlo;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_arith  = start && !op[2];
        op_mthi   = start && (op == 3'b100);
        op_mtlo   = start && (op == 3'b101);
        a_neg     = !op[0] && a[WIDTH-1];
        b_neg     = !op[0] && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
        // b == 0 still runs the full loop; the remainder path already yields a
        quo_fix   = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem_fix   = neg_r ? -acc_hi : acc_hi;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (!flush && op_arith) state_next = RUN;
            RUN: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIN) && !flush;
            unique case (state)
                IDLE: begin
                    if (!flush) begin
                        if (op_mthi) hi <= a;
                        if (op_mtlo) lo <= a;
                        if (op_arith) begin
                            is_div   <= op[1];
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= op[1] && (b == '0);
                            cnt      <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= op[1] ? a_mag : b_mag;
                            opnd     <= op[1] ? b_mag : a_mag;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                                  : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an
// arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2,
                           DIVU = 3'd3, MTHI = 3'd4, MTLO = 3'd5;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // returns {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p = '0;
        case (o)
            MULT:  p = 64'(sx * sy);
            MULTU: p = {32'd0, x} * {32'd0, y};
            DIV: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                if (y == 0) p = {x, 32'hFFFFFFFF};
                else p = {x % y, x / y};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // called at a negedge; returns at the negedge where done should be high
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [63:0] e;
        int n;
        e = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_pulse", 64'(done), 64'd1);
        chk("hi_result", 64'(hi), 64'(e[63:32]));
        chk("lo_result", 64'(lo), 64'(e[31:0]));
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] x);
        start = 1'b1; op = o; a = x;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [2:0] ro;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start = 1'b1; op = MTHI; a = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'h12345678);
        chk("mthi_lo", 64'(lo), 64'd0);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = MTLO; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        chk("mtlo_hi", 64'(hi), 64'h12345678);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(MULTU, 32'd5, 32'd7);

        run_op(MULT, 32'hFFFFFFFE, 32'd3);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("hold_hi", 64'(hi), 64'hFFFFFFFF);
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(DIV, 32'hFFFFFFF9, 32'd2);
        run_op(DIV, 32'd7, 32'hFFFFFFFE);
        run_op(DIVU, 32'd7, 32'd0);
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op(MULT, 32'h80000000, 32'h80000000);
        run_op(DIV, 32'hFFFFFFF9, 32'd0);

        @(negedge clk);
        mt(MTHI, 32'd1);
        mt(MTLO, 32'd2);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_hi", 64'(hi), 64'd1);
        chk("flush_lo", 64'(lo), 64'd2);
        @(negedge clk);
        chk("flush_done2", 64'(done), 64'd0);
        chk("flush_lo2", 64'(lo), 64'd2);
        run_op(DIVU, 32'd100, 32'd3);

        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        chk("fin_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("finflush_done", 64'(done), 64'd0);
        chk("finflush_busy", 64'(busy), 64'd0);
        chk("finflush_hi", 64'(hi), 64'd1);
        chk("finflush_lo", 64'(lo), 64'd33);

        start = 1'b1; flush = 1'b1; op = MULTU;
        @(negedge clk);
        chk("idle_flush_start", 64'(busy), 64'd0);
        op = MTHI; a = 32'hAAAA5555;
        @(negedge clk);
        chk("idle_flush_mthi", 64'(hi), 64'd1);
        flush = 1'b0; op = 3'd6;
        @(negedge clk);
        start = 1'b0;
        chk("reserved_busy", 64'(busy), 64'd0);
        chk("reserved_hi", 64'(hi), 64'd1);
        chk("reserved_lo", 64'(lo), 64'd33);

        start = 1'b1; op = MULTU; a = 32'h00010000; b = 32'h00030000;
        @(negedge clk);
        op = MTHI; a = 32'hDEADBEEF;
        repeat (31) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_mthi_fin_busy", 64'(busy), 64'd1);
        chk("busy_mthi_hi_held", 64'(hi), 64'd1);
        @(negedge clk);
        chk("busy_mthi_done", 64'(done), 64'd1);
        chk("busy_mthi_hi", 64'(hi), 64'd3);
        chk("busy_mthi_lo", 64'(lo), 64'd0);

        // back-to-back: each new op is issued in the done cycle of the last
        for (int i = 0; i < 1200; i++) begin
            ro = 3'($urandom_range(0, 3));
            run_op(ro, rnd32(), rnd32());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
